// File: rtl/fft_source_capture.sv
// fft_source_capture
// Captures one frame from an FFT source-side stream and stores the per-bin
// magnitude (max(|re|,|im|) + min(|re|,|im|)/2) in a block RAM. The frame is
// held for a reader until it releases it.
//
// Ports:
//   MCLK, reset        - sole clock (rising edge) and synchronous active-high reset
//   source_valid/sop/eop, source_real/imag, source_exp, source_error
//                      - FFT output stream; source_ready is the backpressure
//   rd_addr / rd_data  - registered magnitude read port, one cycle latency
//   frame_release      - reader is done with the held frame
//   frame_done         - one-cycle pulse once the last bin of a good frame is in RAM
//   busy               - capturing or holding a frame
//   err_sop/len/fft    - sticky error flags (stray sop, bad length, FFT error code)
//   frame_exp          - block exponent latched from the frame's sop beat
module fft_source_capture #(
    parameter int DATA_W     = 24,
    parameter int FFT_LEN    = 4096,
    parameter int STORE_BINS = 2048,
    localparam int IDX_W     = $clog2(FFT_LEN),
    localparam int ADDR_W    = $clog2(STORE_BINS)
) (
    input  logic              MCLK,
    input  logic              reset,
    input  logic              source_valid,
    input  logic              source_sop,
    input  logic              source_eop,
    input  logic [DATA_W-1:0] source_real,
    input  logic [DATA_W-1:0] source_imag,
    input  logic [5:0]        source_exp,
    input  logic [1:0]        source_error,
    output logic              source_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              frame_release,
    output logic              frame_done,
    output logic              busy,
    output logic              err_sop,
    output logic              err_len,
    output logic              err_fft,
    output logic [5:0]        frame_exp
);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FFT_LEN - 1);
    localparam logic [IDX_W:0]    STORE_LIM = (IDX_W + 1)'(STORE_BINS);
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W - 1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS   = {1'b0, {(DATA_W - 1){1'b1}}};

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;           // index of the next expected beat
    logic [5:0]        frame_exp_q, frame_exp_d;
    logic              err_sop_q, err_sop_d;
    logic              err_len_q, err_len_d;
    logic              err_fft_q, err_fft_d;

    // Magnitude pipeline: stage 1 = absolute values, stage 2 = magnitude
    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q, s1_last_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0] s1_abs_q [2];
    logic [DATA_W-1:0] s1_abs_d [2];
    logic              s2_valid_q, s2_valid_d;
    logic              s2_last_q, s2_last_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
    logic [DATA_W-1:0] s2_mag_q, s2_mag_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] bin_mem [STORE_BINS];

    logic              transfer;
    logic              beat_en;
    logic [IDX_W-1:0]  beat_idx;
    logic [DATA_W-1:0] lane_in  [2];
    logic [DATA_W-1:0] lane_abs [2];
    logic [DATA_W-1:0] mag_max, mag_min;

    assign source_ready = (state_q != HOLD);
    assign transfer     = source_valid && source_ready;

    assign lane_in[0] = source_real;
    assign lane_in[1] = source_imag;

    // Absolute value per lane; the most negative code has no positive
    // counterpart, so it saturates to the largest positive value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            assign lane_abs[gi] = (lane_in[gi] == MOST_NEG) ? MAX_POS :
                                  (lane_in[gi][DATA_W-1] ? (~lane_in[gi] + 1'b1) : lane_in[gi]);
        end
    endgenerate

    // Frame control
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_exp_d = frame_exp_q;
        err_sop_d   = err_sop_q;
        err_len_d   = err_len_q;
        err_fft_d   = err_fft_q;
        beat_en     = 1'b0;
        s1_last_d   = 1'b0;
        // A sop beat always restarts at bin 0
        beat_idx    = source_sop ? '0 : idx_q;

        case (state_q)
            IDLE, CAPTURE: begin
                if (transfer) begin
                    if (source_error != 2'b00) begin
                        // FFT error outranks sop/eop handling; beat dropped
                        err_fft_d = 1'b1;
                        state_d   = IDLE;
                        idx_d     = '0;
                    end else if (state_q == CAPTURE || source_sop) begin
                        if (source_sop) begin
                            frame_exp_d = source_exp;
                            if (state_q == CAPTURE) begin
                                err_sop_d = 1'b1;
                            end
                        end
                        if (source_eop) begin
                            if (beat_idx == LAST_IDX) begin
                                beat_en   = 1'b1;
                                s1_last_d = 1'b1;
                                state_d   = HOLD;
                                idx_d     = '0;
                            end else begin
                                err_len_d = 1'b1;
                                state_d   = IDLE;
                                idx_d     = '0;
                            end
                        end else if (beat_idx == LAST_IDX) begin
                            // Counter does not wrap: a frame longer than FFT_LEN is a length error
                            err_len_d = 1'b1;
                            state_d   = IDLE;
                            idx_d     = '0;
                        end else begin
                            beat_en = 1'b1;
                            state_d = CAPTURE;
                            idx_d   = beat_idx + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (frame_release) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Only bins below STORE_BINS reach the RAM
        s1_valid_d  = beat_en && ({1'b0, beat_idx} < STORE_LIM);
        s1_addr_d   = beat_idx[ADDR_W-1:0];
        s1_abs_d[0] = lane_abs[0];
        s1_abs_d[1] = lane_abs[1];
    end

    // Stage 2: max + min/2 cannot exceed DATA_W bits since both operands
    // are at most 2^(DATA_W-1)-1.
    always_comb begin
        if (s1_abs_q[0] >= s1_abs_q[1]) begin
            mag_max = s1_abs_q[0];
            mag_min = s1_abs_q[1];
        end else begin
            mag_max = s1_abs_q[1];
            mag_min = s1_abs_q[0];
        end
        s2_mag_d     = mag_max + (mag_min >> 1);
        s2_valid_d   = s1_valid_q;
        s2_last_d    = s1_last_q;
        s2_addr_d    = s1_addr_q;
        frame_done_d = s2_last_q;
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            frame_exp_q  <= '0;
            err_sop_q    <= 1'b0;
            err_len_q    <= 1'b0;
            err_fft_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_exp_q  <= frame_exp_d;
            err_sop_q    <= err_sop_d;
            err_len_q    <= err_len_d;
            err_fft_q    <= err_fft_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s2_valid_q   <= s2_valid_d;
            s2_last_q    <= s2_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Datapath registers need no reset; their valids gate every use
    always_ff @(posedge MCLK) begin
        s1_addr_q   <= s1_addr_d;
        s1_abs_q[0] <= s1_abs_d[0];
        s1_abs_q[1] <= s1_abs_d[1];
        s2_addr_q   <= s2_addr_d;
        s2_mag_q    <= s2_mag_d;
    end

    // Bin RAM: reset also cancels a write that is due on the reset edge
    always_ff @(posedge MCLK) begin
        if (s2_valid_q && !reset) begin
            bin_mem[s2_addr_q] <= s2_mag_q;
        end
        rd_data_q <= bin_mem[rd_addr];
    end

    assign rd_data    = rd_data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
    assign err_sop    = err_sop_q;
    assign err_len    = err_len_q;
    assign err_fft    = err_fft_q;
    assign frame_exp  = frame_exp_q;

endmodule
